// File: rtl/led_sequencer.sv
// led_sequencer
//   Drives an 8-LED bar from four 5-bit circulating lane registers. The bar
//   image is mirrored about its centre: LED7..LED4 show lanes 1..4 and
//   LED3..LED0 show lanes 4..1. A prescaler sets the step rate, and a mode
//   handshake selects one of four seed patterns.
//
// Ports
//   clk       in   system clock, rising edge active
//   rst       in   asynchronous active-high reset
//   start     in   begin sequencing from idle, or resume from hold
//   stop      in   pause a running sequence, or return to idle from hold
//   mode      in   [1:0] pattern select, captured on an accepted request
//   mode_req  in   mode-change request level
//   mode_ack  out  one-cycle acknowledge of an accepted request
//   speed     in   [SPEED_W-1:0] step period minus one, in clk cycles
//   dir       in   rotate direction, 0 = right, 1 = left
//   leds      out  [7:0] registered LED image
//   step      out  one-cycle pulse after each pattern advance
//   busy      out  registered, high whenever the sequencer is not idle
//
// State | meaning
// IDLE  | LEDs dark, lanes retained, waiting for start
// LOAD  | one cycle: lanes take the seeds of the current mode
// RUN   | prescaler counting, lanes rotate when it reaches speed
// HOLD  | lanes, LEDs and prescaler frozen

module led_sequencer #(
  parameter int SPEED_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic               mode_req,
  output logic               mode_ack,
  input  logic [SPEED_W-1:0] speed,
  input  logic               dir,
  output logic [7:0]         leds,
  output logic               step,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [SPEED_W-1:0] PRESC_ONE = {{(SPEED_W-1){1'b0}}, 1'b1};

  state_t             state;
  state_t             state_nx;
  logic [4:0]         l1;
  logic [4:0]         l2;
  logic [4:0]         l3;
  logic [4:0]         l4;
  logic [SPEED_W-1:0] presc;
  logic [1:0]         mode_cur;
  logic               pending;

  logic               accept;
  logic               tick;
  logic               do_load;
  logic               do_rot;
  logic               presc_inc;
  logic               clr_leds;
  logic               pend_set;
  logic               pend_clr;

  logic [19:0]        seed_vec;
  logic [4:0]         r1;
  logic [4:0]         r2;
  logic [4:0]         r3;
  logic [4:0]         r4;

  // Seeds packed as {L1, L2, L3, L4}.
  function automatic logic [19:0] seeds_of(input logic [1:0] m);
    logic [19:0] s;
    case (m)
      2'd0:    s = {5'b10001, 5'b10100, 5'b10010, 5'b11000};
      2'd1:    s = {5'b00001, 5'b00001, 5'b00001, 5'b00001};
      2'd2:    s = {5'b00001, 5'b00010, 5'b00100, 5'b01000};
      default: s = {5'b10101, 5'b01010, 5'b10101, 5'b01010};
    endcase
    return s;
  endfunction

  function automatic logic [4:0] rotate(input logic [4:0] v, input logic left);
    return left ? {v[3:0], v[4]} : {v[0], v[4:1]};
  endfunction

  function automatic logic [7:0] image(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] c, input logic [4:0] d);
    return {a[0], b[0], c[0], d[0], d[0], c[0], b[0], a[0]};
  endfunction

  // A request held high is only taken while no acknowledge is showing, so
  // a level request is accepted at most every other cycle.
  assign accept   = mode_req & ~mode_ack;
  // The >= compare lets a speed reduction mid-count fire at once instead of
  // letting the prescaler wrap.
  assign tick     = (presc >= speed);

  assign seed_vec = seeds_of(mode_cur);
  assign r1       = rotate(l1, dir);
  assign r2       = rotate(l2, dir);
  assign r3       = rotate(l3, dir);
  assign r4       = rotate(l4, dir);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    do_load   = 1'b0;
    do_rot    = 1'b0;
    presc_inc = 1'b0;
    clr_leds  = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx = LOAD;
        end
      end
      LOAD: begin
        do_load  = 1'b1;
        pend_clr = 1'b1;
        // A mode taken during LOAD is only latched on this edge, so LOAD
        // runs once more to pick up its seeds.
        state_nx = accept ? LOAD : RUN;
      end
      RUN: begin
        // Reload outranks stop; neither lets the lanes advance this edge.
        if (accept) begin
          state_nx = LOAD;
        end else if (stop) begin
          state_nx = HOLD;
        end else if (tick) begin
          do_rot = 1'b1;
        end else begin
          presc_inc = 1'b1;
        end
      end
      HOLD: begin
        if (stop) begin
          state_nx = IDLE;
          clr_leds = 1'b1;
          pend_clr = 1'b1;
        end else begin
          if (accept) begin
            pend_set = 1'b1;
          end
          if (start) begin
            state_nx = (pending || accept) ? LOAD : RUN;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l1       <= '0;
      l2       <= '0;
      l3       <= '0;
      l4       <= '0;
      presc    <= '0;
      mode_cur <= '0;
      pending  <= 1'b0;
      leds     <= '0;
      step     <= 1'b0;
      mode_ack <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy     <= (state_nx != IDLE);
      step     <= do_rot;
      mode_ack <= accept;
      if (accept) begin
        mode_cur <= mode;
      end

      if (pend_clr) begin
        pending <= 1'b0;
      end else if (pend_set) begin
        pending <= 1'b1;
      end

      if (do_load) begin
        l1    <= seed_vec[19:15];
        l2    <= seed_vec[14:10];
        l3    <= seed_vec[9:5];
        l4    <= seed_vec[4:0];
        leds  <= image(seed_vec[19:15], seed_vec[14:10], seed_vec[9:5], seed_vec[4:0]);
        presc <= '0;
      end else if (do_rot) begin
        l1    <= r1;
        l2    <= r2;
        l3    <= r3;
        l4    <= r4;
        leds  <= image(r1, r2, r3, r4);
        presc <= '0;
      end else if (presc_inc) begin
        presc <= presc + PRESC_ONE;
      end

      if (clr_leds) begin
        leds <= '0;
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer
//   Directed bench for led_sequencer. Each step pushes the expected
//   {leds, step, busy, mode_ack} onto a scoreboard queue as the stimulus is
//   driven; the entry is popped and compared on the following falling edge.
//   A small lane model supplies the LED images between the fixed patterns.

module tb_led_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic       mode_req;
  logic       mode_ack;
  logic [3:0] speed;
  logic       dir;
  logic [7:0] leds;
  logic       step;
  logic       busy;

  int errors = 0;
  int checks = 0;

  string      tag_q[$];
  logic [10:0] exp_q[$];

  logic [4:0] ml [4];

  led_sequencer #(.SPEED_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .mode_req (mode_req),
    .mode_ack (mode_ack),
    .speed    (speed),
    .dir      (dir),
    .leds     (leds),
    .step     (step),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] seed(input int md, input int i);
    logic [4:0] s;
    case (md)
      0: case (i)
           0: s = 5'b10001;
           1: s = 5'b10100;
           2: s = 5'b10010;
           default: s = 5'b11000;
         endcase
      1: s = 5'b00001;
      2: case (i)
           0: s = 5'b00001;
           1: s = 5'b00010;
           2: s = 5'b00100;
           default: s = 5'b01000;
         endcase
      default: s = (i % 2 == 0) ? 5'b10101 : 5'b01010;
    endcase
    return s;
  endfunction

  task automatic m_load(input int md);
    for (int i = 0; i < 4; i++) ml[i] = seed(md, i);
  endtask

  task automatic m_rot(input logic left);
    for (int i = 0; i < 4; i++)
      ml[i] = left ? {ml[i][3:0], ml[i][4]} : {ml[i][0], ml[i][4:1]};
  endtask

  function automatic logic [7:0] m_img();
    return {ml[0][0], ml[1][0], ml[2][0], ml[3][0],
            ml[3][0], ml[2][0], ml[1][0], ml[0][0]};
  endfunction

  task automatic push_exp(input string tag, input logic [7:0] l, input logic s,
                          input logic b, input logic a);
    tag_q.push_back(tag);
    exp_q.push_back({l, s, b, a});
  endtask

  task automatic pop_cmp();
    string       tag;
    logic [10:0] e;
    tag = tag_q.pop_front();
    e   = exp_q.pop_front();
    checks++;
    assert (leds === e[10:3]) else begin
      errors++;
      $error("FAIL %s leds: observed %b expected %b", tag, leds, e[10:3]);
    end
    checks++;
    assert (step === e[2]) else begin
      errors++;
      $error("FAIL %s step: observed %b expected %b", tag, step, e[2]);
    end
    checks++;
    assert (busy === e[1]) else begin
      errors++;
      $error("FAIL %s busy: observed %b expected %b", tag, busy, e[1]);
    end
    checks++;
    assert (mode_ack === e[0]) else begin
      errors++;
      $error("FAIL %s mode_ack: observed %b expected %b", tag, mode_ack, e[0]);
    end
  endtask

  // One clock: expectation queued with the stimulus, checked after the edge.
  task automatic cyc(input string tag, input logic [7:0] l, input logic s,
                     input logic b, input logic a);
    push_exp(tag, l, s, b, a);
    @(negedge clk);
    pop_cmp();
  endtask

  task automatic now_chk(input string tag, input logic [7:0] l, input logic s,
                         input logic b, input logic a);
    push_exp(tag, l, s, b, a);
    pop_cmp();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    mode     = 2'd0;
    mode_req = 1'b0;
    speed    = 4'd0;
    dir      = 1'b0;
    for (int i = 0; i < 4; i++) ml[i] = '0;

    @(negedge clk);
    @(negedge clk);
    now_chk("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("idle_quiet", 8'h00, 1'b0, 1'b0, 1'b0);

    // Mode 0, speed 0, rotate right
    start = 1'b1;
    cyc("a_idle_to_load", 8'h00, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    m_load(0);
    cyc("a_load_img", 8'b10000001, 1'b0, 1'b1, 1'b0);
    m_rot(1'b0);
    cyc("a_step1", 8'b00100100, 1'b1, 1'b1, 1'b0);
    m_rot(1'b0);
    cyc("a_step2", 8'b01000010, 1'b1, 1'b1, 1'b0);

    // Speed 3: steps four cycles apart, then a mid-count drop to 0
    speed = 4'd3;
    repeat (3) cyc("b_wait_a", m_img(), 1'b0, 1'b1, 1'b0);
    m_rot(1'b0);
    cyc("b_step_a", m_img(), 1'b1, 1'b1, 1'b0);
    repeat (3) cyc("b_wait_b", m_img(), 1'b0, 1'b1, 1'b0);
    m_rot(1'b0);
    cyc("b_step_b", m_img(), 1'b1, 1'b1, 1'b0);
    repeat (2) cyc("b_wait_c", m_img(), 1'b0, 1'b1, 1'b0);
    speed = 4'd0;
    dir   = 1'b1;
    m_rot(1'b1);
    cyc("b_speed_drop", m_img(), 1'b1, 1'b1, 1'b0);
    m_rot(1'b1);
    cyc("b_left_step", m_img(), 1'b1, 1'b1, 1'b0);

    // Stop -> hold -> idle; start with stop does nothing
    stop = 1'b1;
    cyc("c_run_to_hold", m_img(), 1'b0, 1'b1, 1'b0);
    stop = 1'b0;
    repeat (2) cyc("c_hold_frozen", m_img(), 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    cyc("c_hold_to_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    repeat (2) cyc("c_start_and_stop", 8'h00, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    stop  = 1'b0;

    // Mode request in RUN forces a reload and restarts the prescaler
    dir   = 1'b0;
    speed = 4'd7;
    start = 1'b1;
    cyc("d_idle_to_load", 8'h00, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    m_load(0);
    cyc("d_load", 8'b10000001, 1'b0, 1'b1, 1'b0);
    repeat (2) cyc("d_count", m_img(), 1'b0, 1'b1, 1'b0);
    mode     = 2'd2;
    mode_req = 1'b1;
    cyc("d_accept", m_img(), 1'b0, 1'b1, 1'b1);
    mode_req = 1'b0;
    m_load(2);
    cyc("d_reload", 8'b10000001, 1'b0, 1'b1, 1'b0);
    repeat (7) cyc("d_prescale", m_img(), 1'b0, 1'b1, 1'b0);
    m_rot(1'b0);
    cyc("d_first_step", 8'b01000010, 1'b1, 1'b1, 1'b0);

    // Mode request in HOLD: held level acks every other cycle, then reload on start
    stop = 1'b1;
    cyc("e_run_to_hold", m_img(), 1'b0, 1'b1, 1'b0);
    stop     = 1'b0;
    mode     = 2'd3;
    mode_req = 1'b1;
    cyc("e_ack_1", m_img(), 1'b0, 1'b1, 1'b1);
    cyc("e_ack_2", m_img(), 1'b0, 1'b1, 1'b0);
    cyc("e_ack_3", m_img(), 1'b0, 1'b1, 1'b1);
    cyc("e_ack_4", m_img(), 1'b0, 1'b1, 1'b0);
    mode_req = 1'b0;
    start    = 1'b1;
    cyc("e_hold_to_load", m_img(), 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    m_load(3);
    cyc("e_load_mode3", 8'b10100101, 1'b0, 1'b1, 1'b0);

    // Switch to mode 1, then reset asynchronously mid-RUN
    mode     = 2'd1;
    mode_req = 1'b1;
    cyc("f_accept", m_img(), 1'b0, 1'b1, 1'b1);
    mode_req = 1'b0;
    m_load(1);
    cyc("f_load_mode1", 8'hFF, 1'b0, 1'b1, 1'b0);
    cyc("f_run", 8'hFF, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 now_chk("f_async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // After reset the mode is 0 again; a request during LOAD repeats LOAD
    start = 1'b1;
    cyc("g_idle_to_load", 8'h00, 1'b0, 1'b1, 1'b0);
    start    = 1'b0;
    mode     = 2'd3;
    mode_req = 1'b1;
    m_load(0);
    cyc("g_load_mode0", 8'b10000001, 1'b0, 1'b1, 1'b1);
    mode_req = 1'b0;
    m_load(3);
    cyc("g_load_repeat", 8'b10100101, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter: SPEED_W, default 4, width of the speed input and prescaler counter.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: start  in  1  level, sampled each clk edge; begin or resume sequencing.
REQ-005 Port: stop  in  1  level, sampled each clk edge; pause, or from pause return to idle.
REQ-006 Port: mode  in  2  pattern select, captured only on an accepted mode request.
REQ-007 Port: mode_req  in  1  mode-change request, level.
REQ-008 Port: mode_ack  out  1  one-cycle acknowledge of an accepted mode request.
REQ-009 Port: speed  in  SPEED_W  step period minus one, in clk cycles.
REQ-010 Port: dir  in  1  rotate direction: 0 = right, 1 = left.
REQ-011 Port: leds  out  8  registered LED image.
REQ-012 Port: step  out  1  one-cycle pulse on each pattern advance.
REQ-013 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-014 Datapath: four 5-bit lane registers L1..L4; leds = {L1[0],L2[0],L3[0],L4[0],L4[0],L3[0],L2[0],L1[0]}, mirrored about the centre.
REQ-015 Seeds for L1..L4 by mode: 0 = 10001,10100,10010,11000; 1 = 00001 ×4; 2 = 00001,00010,00100,01000; 3 = 10101,01010,10101,01010.
REQ-016 Rotate right (dir=0): L <= {L[0],L[4:1]}; rotate left (dir=1): L <= {L[3:0],L[4]}; all four lanes rotate together; dir is sampled at each step.
REQ-017 FSM states are IDLE, LOAD, RUN and HOLD.
REQ-018 IDLE: leds = 0 and lanes are unchanged; start=1 and stop=0 -> LOAD.
REQ-019 LOAD lasts exactly one cycle: lanes <= seeds of the current mode; leds <= image of the seeds in the same edge; prescaler <= 0; then -> RUN.
REQ-020 RUN: the prescaler increments each cycle; when prescaler >= speed, prescaler <= 0, lanes rotate, leds <= image of the rotated lanes, and step = 1 in the following cycle.
REQ-021 With a constant speed, step fires every speed+1 cycles; the first step occurs speed+1 cycles after LOAD.
REQ-022 RUN with stop=1 -> HOLD; no step occurs on that edge.
REQ-023 HOLD freezes lanes, leds and prescaler.
REQ-024 HOLD with stop=1 -> IDLE, and leds <= 0.
REQ-025 HOLD with start=1 and stop=0 -> RUN if no reload is pending, otherwise -> LOAD.
REQ-026 When start and stop are high together, stop wins in every state.
REQ-027 A mode request is accepted when mode_req=1 and mode_ack=0: the current mode <= mode, and mode_ack = 1 in the next cycle.
REQ-028 A request held high is therefore accepted at most every other cycle; the requester drops mode_req after seeing mode_ack.
REQ-029 Mode request accepted in RUN: the next state is LOAD, so new seeds appear one cycle later and the prescaler restarts; this takes priority over stop on the same edge.
REQ-030 Mode request accepted in HOLD: the pending-reload flag is set; it is cleared by the next LOAD or by entry to IDLE.
REQ-031 Mode request accepted in IDLE or LOAD: latch the mode only; in IDLE it applies at the next LOAD; if accepted during LOAD, LOAD repeats once with the new mode.
REQ-032 A speed change mid-count takes effect immediately through the >= comparison; the prescaler never wraps past speed.
REQ-033 busy is registered and equals (state != IDLE).

Reset
REQ-034 When rst is asserted, all outputs and registers clear asynchronously: state = IDLE, L1..L4 = 0, prescaler = 0, current mode = 0, pending reload = 0, leds = 0, step = 0, mode_ack = 0, busy = 0.
REQ-035 When rst is asserted mid-RUN, the next pulse on start shall reload mode-0 seeds.
REQ-036 rst release is synchronous-safe: the first active edge after deassertion follows normal IDLE rules.

Verification
REQ-037 Mode 0, speed 0, dir 0, pulse start -> leds 10000001 one edge later, then 00100100, then 01000010, with step pulses each cycle.
REQ-038 Speed 3, RUN -> step spaced exactly 4 cycles; lower speed to 0 mid-count -> step on the very next edge.
REQ-039 Stop in RUN -> leds frozen and busy=1; stop again -> leds 00000000 and busy=0; start and stop together -> no state advance from IDLE.
REQ-040 mode_req with mode=2 during RUN -> mode_ack pulse, then LOAD, then leds = 10000001 (L1 seed 00001), with the prescaler restarted.
REQ-041 mode_req with mode=3 in HOLD, then start -> LOAD, leds = 10100101; mode_req held 4 cycles -> mode_ack toggles 0,1,0,1.
REQ-042 Assert rst mid-RUN with mode 1 -> all outputs 0 immediately; start -> mode-0 image 10000001.
